alu_regfile: RTL and testbench

//   Datapath core: an 8 x 8-bit register file feeding an 8-bit combinational ALU.
//   The ALU result is written back into the register file.

---
 rtl/alu_regfile.sv | 114 +++++++++++
 tb/tb_alu_regfile.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_regfile.sv
// ============================================================================
// Module   : alu_regfile
// Purpose  : 8-entry register file feeding a combinational ALU with write-back.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_regfile #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [AW-1:0] wr_addr,
  input  logic          rd,
  input  logic          wr,
  input  logic          ld,
  input  logic [DW-1:0] data_in,
  input  logic [2:0]    alu_ctrl,
  output logic [DW-1:0] data_out1,
  output logic [DW-1:0] data_out2,
  output logic [DW-1:0] alu_out,
  output logic          cy,
  output logic          zero,
  output logic          cy_flag,
  output logic          zero_flag
);

  localparam int          c_NREGS = 2 ** AW;
  localparam logic [2:0]  c_OP_ADD = 3'b000;
  localparam logic [2:0]  c_OP_SUB = 3'b001;
  localparam logic [2:0]  c_OP_AND = 3'b010;
  localparam logic [2:0]  c_OP_OR  = 3'b011;
  localparam logic [2:0]  c_OP_XOR = 3'b100;
  localparam logic [2:0]  c_OP_NOT = 3'b101;
  localparam logic [2:0]  c_OP_SHL = 3'b110;
  localparam logic [2:0]  c_OP_SHR = 3'b111;

  logic [DW-1:0] regs_q [c_NREGS];
  logic [DW-1:0] op_a_q;
  logic [DW-1:0] op_b_q;
  logic          cy_flag_q;
  logic          zero_flag_q;

  logic [DW-1:0] w_res;
  logic          w_cy;
  logic          w_zero;

  always_comb begin
    w_res = '0;
    w_cy  = 1'b0;
    case (alu_ctrl)
      c_OP_ADD: {w_cy, w_res} = {1'b0, op_a_q} + {1'b0, op_b_q};
      // The extra top bit of the 9-bit difference is the unsigned borrow.
      c_OP_SUB: {w_cy, w_res} = {1'b0, op_a_q} - {1'b0, op_b_q};
      c_OP_AND: w_res = op_a_q & op_b_q;
      c_OP_OR:  w_res = op_a_q | op_b_q;
      c_OP_XOR: w_res = op_a_q ^ op_b_q;
      c_OP_NOT: w_res = ~op_a_q;
      c_OP_SHL: begin
        w_res = {op_a_q[DW-2:0], 1'b0};
        w_cy  = op_a_q[DW-1];
      end
      c_OP_SHR: begin
        w_res = {1'b0, op_a_q[DW-1:1]};
        w_cy  = op_a_q[0];
      end
      default: begin
        w_res = '0;
        w_cy  = 1'b0;
      end
    endcase
  end

  assign w_zero = (w_res == '0);

  // Operand capture reads the pre-edge array, so a same-cycle write is not bypassed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_NREGS; i++) begin
        regs_q[i] <= '0;
      end
      op_a_q      <= '0;
      op_b_q      <= '0;
      cy_flag_q   <= 1'b0;
      zero_flag_q <= 1'b0;
    end else begin
      if (rd) begin
        op_a_q <= regs_q[addr1];
        op_b_q <= regs_q[addr2];
      end
      if (ld) begin
        regs_q[wr_addr] <= data_in;
      end else if (wr) begin
        regs_q[wr_addr] <= w_res;
        cy_flag_q       <= w_cy;
        zero_flag_q     <= w_zero;
      end
    end
  end

  assign data_out1 = op_a_q;
  assign data_out2 = op_b_q;
  assign alu_out   = w_res;
  assign cy        = w_cy;
  assign zero      = w_zero;
  assign cy_flag   = cy_flag_q;
  assign zero_flag = zero_flag_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_regfile.sv
// ============================================================================
// Module   : tb_alu_regfile
// Purpose  : Directed scoreboard bench for alu_regfile.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_regfile;

  logic       clk;
  logic       rst;
  logic [2:0] addr1, addr2, wr_addr;
  logic       rd, wr, ld;
  logic [7:0] data_in;
  logic [2:0] alu_ctrl;
  logic [7:0] data_out1, data_out2, alu_out;
  logic       cy, zero, cy_flag, zero_flag;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  alu_regfile #(.DW(8), .AW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr1     (addr1),
    .addr2     (addr2),
    .wr_addr   (wr_addr),
    .rd        (rd),
    .wr        (wr),
    .ld        (ld),
    .data_in   (data_in),
    .alu_ctrl  (alu_ctrl),
    .data_out1 (data_out1),
    .data_out2 (data_out2),
    .alu_out   (alu_out),
    .cy        (cy),
    .zero      (zero),
    .cy_flag   (cy_flag),
    .zero_flag (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [7:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    ld = 1'b1; wr_addr = a; data_in = d;
    cyc();
    ld = 1'b0;
  endtask

  task automatic read(input logic [2:0] a1, input logic [2:0] a2);
    rd = 1'b1; addr1 = a1; addr2 = a2;
    cyc();
    rd = 1'b0;
  endtask

  task automatic wback(input logic [2:0] a);
    wr = 1'b1; wr_addr = a;
    cyc();
    wr = 1'b0;
  endtask

  // Full ALU truth for A=A5, B=0F: {op, result, carry}
  logic [2:0] op_tab  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [7:0] res_tab [8] = '{8'hB4, 8'h96, 8'h05, 8'hAF, 8'hAA, 8'h5A, 8'h4A, 8'h52};
  logic       cy_tab  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; ld = 1'b0;
    addr1 = '0; addr2 = '0; wr_addr = '0; data_in = '0; alu_ctrl = 3'd0;
    cyc(); cyc();
    rst = 1'b0;

    push("rst_dout1", 8'h00);     pop_chk(data_out1);
    push("rst_dout2", 8'h00);     pop_chk(data_out2);
    push("rst_cyflag", 8'h00);    pop_chk({7'd0, cy_flag});
    push("rst_zflag", 8'h00);     pop_chk({7'd0, zero_flag});
    for (int i = 0; i < 8; i++) begin
      push("rst_reg_read", 8'h00);
      read(3'(i), 3'(7 - i));
      pop_chk(data_out1);
    end
    alu_ctrl = 3'd0; #1;
    push("rst_add_out", 8'h00);   pop_chk(alu_out);
    push("rst_add_zero", 8'h01);  pop_chk({7'd0, zero});

    // Load + ADD + write-back
    load(3'd1, 8'h05);
    load(3'd2, 8'h03);
    read(3'd1, 3'd2);
    alu_ctrl = 3'd0; #1;
    push("add_out", 8'h08);       pop_chk(alu_out);
    push("add_cy", 8'h00);        pop_chk({7'd0, cy});
    wback(3'd3);
    push("add_cyflag", 8'h00);    pop_chk({7'd0, cy_flag});
    push("add_zflag", 8'h00);     pop_chk({7'd0, zero_flag});
    push("add_wb_read", 8'h08);
    read(3'd3, 3'd3);
    pop_chk(data_out1);

    // Carry / zero
    load(3'd1, 8'hFF);
    load(3'd2, 8'h01);
    read(3'd1, 3'd2);
    push("cz_out", 8'h00);        pop_chk(alu_out);
    push("cz_cy", 8'h01);         pop_chk({7'd0, cy});
    push("cz_zero", 8'h01);       pop_chk({7'd0, zero});
    wback(3'd4);
    push("cz_cyflag", 8'h01);     pop_chk({7'd0, cy_flag});
    push("cz_zflag", 8'h01);      pop_chk({7'd0, zero_flag});

    // SUB borrow, then swapped operands
    load(3'd1, 8'h02);
    load(3'd2, 8'h05);
    read(3'd1, 3'd2);
    alu_ctrl = 3'd1; #1;
    push("sub_out", 8'hFD);       pop_chk(alu_out);
    push("sub_borrow", 8'h01);    pop_chk({7'd0, cy});
    read(3'd2, 3'd1);
    push("subsw_out", 8'h03);     pop_chk(alu_out);
    push("subsw_borrow", 8'h00);  pop_chk({7'd0, cy});

    // All operations on A=A5, B=0F
    load(3'd5, 8'hA5);
    load(3'd6, 8'h0F);
    read(3'd5, 3'd6);
    for (int k = 0; k < 8; k++) begin
      alu_ctrl = op_tab[k]; #1;
      push($sformatf("op%0d_out", k), res_tab[k]);     pop_chk(alu_out);
      push($sformatf("op%0d_cy", k), {7'd0, cy_tab[k]}); pop_chk({7'd0, cy});
    end

    // Same-cycle rd and wr to r1: AND gives 05, read must see old 02
    alu_ctrl = 3'd2;
    rd = 1'b1; addr1 = 3'd1; addr2 = 3'd1;
    wr = 1'b1; wr_addr = 3'd1;
    push("haz_old_val", 8'h02);
    cyc();
    rd = 1'b0; wr = 1'b0;
    pop_chk(data_out1);
    push("haz_new_val", 8'h05);
    read(3'd1, 3'd1);
    pop_chk(data_out1);
    push("haz_cyflag", 8'h00);    pop_chk({7'd0, cy_flag});
    push("haz_zflag", 8'h00);     pop_chk({7'd0, zero_flag});

    // ld with wr: SUB 05-05 would set zero, but load wins and flags hold
    alu_ctrl = 3'd1;
    ld = 1'b1; wr = 1'b1; wr_addr = 3'd7; data_in = 8'h3C;
    cyc();
    ld = 1'b0; wr = 1'b0;
    push("ldwr_zflag", 8'h00);    pop_chk({7'd0, zero_flag});
    push("ldwr_cyflag", 8'h00);   pop_chk({7'd0, cy_flag});
    push("ldwr_data", 8'h3C);
    read(3'd7, 3'd7);
    pop_chk(data_out1);

    // Register 0 is writable, operands hold with rd low
    load(3'd0, 8'h77);
    push("r0_write", 8'h77);
    read(3'd0, 3'd0);
    pop_chk(data_out1);
    addr1 = 3'd7;
    cyc();
    push("rd_hold", 8'h77);       pop_chk(data_out1);

    // Reset during write-back: ADD 77+77 must not land in r0
    alu_ctrl = 3'd0;
    rst = 1'b1; wr = 1'b1; wr_addr = 3'd0;
    cyc();
    rst = 1'b0; wr = 1'b0;
    push("rstwr_cyflag", 8'h00);  pop_chk({7'd0, cy_flag});
    push("rstwr_dout1", 8'h00);   pop_chk(data_out1);
    push("rstwr_r0", 8'h00);
    read(3'd0, 3'd0);
    pop_chk(data_out1);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
